mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum cycles spent waiting for mem_ack before abort; it is used only when MEM_TIMEOUT_EN is defined.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have port MemWrite  input  1  store request from the EX/MEM pipeline register.
REQ-005 The block SHALL have port MemToReg  input  1  load request from the EX/MEM pipeline register.
REQ-006 The block SHALL have port Daddr  input  64  access address from the EX/MEM pipeline register.
REQ-007 The block SHALL have port Db  input  64  store data from the EX/MEM pipeline register.
REQ-008 The block SHALL have port mem_req  output  1  request to the data memory.
REQ-009 The block SHALL have port mem_we  output  1  write strobe qualifying mem_req.
REQ-010 The block SHALL have port mem_addr  output  64  latched access address.
REQ-011 The block SHALL have port mem_wdata  output  64  latched store data.
REQ-012 The block SHALL have port mem_ack  input  1  one-cycle completion pulse from the data memory.
REQ-013 The block SHALL have port mem_rdata  input  64  load data, valid when mem_ack=1.
REQ-014 The block SHALL have port stall  output  1  freeze for the upstream pipeline registers.
REQ-015 The block SHALL have port rdata_out  output  64  registered load result.
REQ-016 The block SHALL have port rdata_valid  output  1  rdata_out is valid this cycle.
REQ-017 The block SHALL have port timeout_err  output  1  access aborted by timeout.

Function
REQ-018 The FSM SHALL have three states, IDLE, REQ and DONE, held in registered state.
REQ-019 IDLE with MemWrite|MemToReg=1: stall SHALL be 1 combinationally; at the edge the block SHALL latch Daddr into mem_addr, latch Db into mem_wdata, latch mem_we=MemWrite, and go to REQ.
REQ-020 IDLE with no request: stall SHALL be 0 and the FSM SHALL stay in IDLE.
REQ-021 If MemWrite and MemToReg are both 1, the access SHALL be a store; rdata_valid SHALL NOT assert.
REQ-022 REQ: mem_req=1 and stall=1; mem_addr, mem_wdata and mem_we SHALL be stable until exit.
REQ-023 REQ with mem_ack=1: at the edge the block SHALL capture rdata_out=mem_rdata (loads only) and go to DONE.
REQ-024 DONE: mem_req=0, stall=0, rdata_valid=1 for one cycle if the access was a load; next state SHALL be IDLE.
REQ-025 The minimum access, with mem_ack in the first REQ cycle, SHALL take 3 cycles (IDLE, REQ, DONE), with stall high for 2.
REQ-026 mem_ack in IDLE or DONE SHALL be ignored, with no state or output change.
REQ-027 rdata_out SHALL hold its value until the next completed load.
REQ-028 A store SHALL leave rdata_out unchanged.

Reset
REQ-029 reset=0 at a rising edge SHALL force state=IDLE and mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_out=0, rdata_valid=0, timeout_err=0, and clear the timeout counter.
REQ-030 Reset asserted during REQ SHALL abort the access; mem_req SHALL be 0 in the cycle after the edge.
REQ-031 stall SHALL be 0 while reset=0.

Configuration
REQ-032 With MEM_TIMEOUT_EN defined: a counter SHALL clear on entry to REQ and increment each REQ cycle without ack; when it reaches TIMEOUT_CYCLES the FSM SHALL go to DONE with timeout_err=1 for that DONE cycle, rdata_out=0 and rdata_valid=0.
REQ-033 With MEM_TIMEOUT_EN defined, mem_ack arriving in the same cycle as timeout SHALL win: normal completion, timeout_err=0.
REQ-034 Without MEM_TIMEOUT_EN: no counter SHALL exist, REQ SHALL wait indefinitely, and timeout_err SHALL be tied to 0 (port retained).

Verification
REQ-035 The bench SHALL cover: load, Daddr=0x40, mem_ack in the 2nd REQ cycle with mem_rdata=0xDEAD -> mem_addr=0x40, mem_we=0, stall high 3 cycles, rdata_out=0xDEAD with rdata_valid=1 for one cycle.
REQ-036 The bench SHALL cover: store, Daddr=0x8, Db=0x1234, immediate ack -> mem_we=1, mem_wdata=0x1234, stall high 2 cycles, rdata_valid=0, rdata_out unchanged.
REQ-037 The bench SHALL cover: MemWrite=MemToReg=1 -> treated as a store with mem_we=1 and no rdata_valid.
REQ-038 The bench SHALL cover: reset=0 during the 3rd REQ cycle -> next cycle mem_req=0, stall=0, state IDLE; a subsequent load completes normally.
REQ-039 The bench SHALL cover, with MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: no ack -> DONE after 4 REQ cycles, timeout_err=1 for one cycle, rdata_out=0; a second run with ack on the 4th cycle -> normal completion, timeout_err=0.
REQ-040 The bench SHALL cover: a spurious mem_ack in IDLE -> no state change and no rdata_valid.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory handshake FSM (IDLE -> REQ -> DONE) with pipeline stall.
// Optional MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES REQ cycles without mem_ack.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemToReg,
    input  logic [63:0] Daddr,
    input  logic [63:0] Db,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        stall,
    output logic [63:0] rdata_out,
    output logic        rdata_valid,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, next_state;
    logic start, ack_hit, tmo_hit;
    assign start   = state == IDLE && (MemWrite || MemToReg);
    assign ack_hit = state == REQ && mem_ack;
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // cnt holds the number of ack-less REQ cycles already elapsed; ack wins a tie
    assign tmo_hit = state == REQ && !mem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk)
        if (!reset || start)
            cnt <= '0;
        else if (state == REQ && !mem_ack)
            cnt <= cnt + 1'b1;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES > 0;
    assign tmo_hit = 1'b0;
`endif
    always_ff @(posedge clk)
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    always_comb
        next_state = state == IDLE ? (start ? REQ : IDLE)
                   : state == REQ  ? (ack_hit || tmo_hit ? DONE : REQ)
                   : IDLE;
    always_comb begin
        mem_req = state == REQ;
        stall   = reset && (start || state == REQ);
    end
    // mem_we doubles as the load/store flag for the access in flight
    always_ff @(posedge clk)
        if (!reset) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata_out   <= '0;
            rdata_valid <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (start) begin
                mem_we    <= MemWrite;
                mem_addr  <= Daddr;
                mem_wdata <= Db;
            end
            if (ack_hit && !mem_we)
                rdata_out <= mem_rdata;
            else if (tmo_hit)
                rdata_out <= '0;
            rdata_valid <= ack_hit && !mem_we;
            timeout_err <= tmo_hit;
        end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized self-checking bench for mem_stage_ctrl against a transaction-level model.
// Define MEM_TIMEOUT_EN to exercise the timeout build with TIMEOUT_CYCLES=4.
module tb_mem_stage_ctrl;
`ifdef MEM_TIMEOUT_EN
    localparam int T = 4;
    localparam bit TMO = 1'b1;
`else
    localparam int T = 16;
    localparam bit TMO = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic MemWrite = 1'b0, MemToReg = 1'b0, mem_ack = 1'b0;
    logic [63:0] Daddr = '0, Db = '0, mem_rdata = '0;
    logic mem_req, mem_we, stall, rdata_valid, timeout_err;
    logic [63:0] mem_addr, mem_wdata, rdata_out;
    int errors = 0;
    int checks = 0;
    logic [63:0] exp_rdata = '0;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .Daddr(Daddr), .Db(Db), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall(stall), .rdata_out(rdata_out),
        .rdata_valid(rdata_valid), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Drives one access and records what was observed; ack comes in the lat-th REQ cycle.
    task automatic do_access(input logic w, input logic r, input logic [63:0] a, input logic [63:0] d,
                             input int lat, input logic [63:0] rd,
                             output int n_stall, output int n_req, output int n_valid, output int n_tmo,
                             output logic [63:0] s_addr, output logic [63:0] s_wdata,
                             output logic [63:0] s_rdata, output logic s_we);
        n_stall = 0; n_req = 0; n_valid = 0; n_tmo = 0;
        s_addr = 'x; s_wdata = 'x; s_rdata = 'x; s_we = 1'bx;
        for (int c = 0; c < lat + 3; c++) begin
            @(negedge clk);
            MemWrite = c == 0 ? w : 1'b0;
            MemToReg = c == 0 ? r : 1'b0;
            Daddr = c == 0 ? a : {$urandom, $urandom};
            Db = c == 0 ? d : {$urandom, $urandom};
            #1;
            if (mem_req) begin
                n_req++;
                s_addr = mem_addr; s_wdata = mem_wdata; s_we = mem_we;
                mem_ack = n_req == lat;
                mem_rdata = n_req == lat ? rd : {$urandom, $urandom};
            end else begin
                mem_ack = 1'($urandom);
                mem_rdata = {$urandom, $urandom};
            end
            if (stall) n_stall++;
            if (rdata_valid) begin n_valid++; s_rdata = rdata_out; end
            if (timeout_err) n_tmo++;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; MemWrite = 1'b1; MemToReg = 1'b1; Daddr = 64'h55; Db = 64'h66; mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 64'd0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 64'd0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        checks++; if (rdata_out !== 64'd0) begin errors++; $display("FAIL reset_rdata_out got %h want 0", rdata_out); end
        checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid got %b want 0", rdata_valid); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
        @(negedge clk);
        reset = 1'b1; MemWrite = 1'b0; MemToReg = 1'b0; mem_ack = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL reset_release_idle got stall=%b req=%b want 0 0", stall, mem_req); end
        exp_rdata = '0;
    endtask

    task automatic test_load();
        int ns, nr, nv, nt; logic [63:0] sa, sw, sr; logic swe;
        do_access(1'b0, 1'b1, 64'h40, 64'h777, 2, 64'hDEAD, ns, nr, nv, nt, sa, sw, sr, swe);
        exp_rdata = 64'hDEAD;
        checks++; if (sa !== 64'h40) begin errors++; $display("FAIL load_addr got %h want 40", sa); end
        checks++; if (swe !== 1'b0) begin errors++; $display("FAIL load_we got %b want 0", swe); end
        checks++; if (ns !== 3) begin errors++; $display("FAIL load_stall_cycles got %0d want 3", ns); end
        checks++; if (nr !== 2) begin errors++; $display("FAIL load_req_cycles got %0d want 2", nr); end
        checks++; if (nv !== 1) begin errors++; $display("FAIL load_valid_cycles got %0d want 1", nv); end
        checks++; if (sr !== 64'hDEAD) begin errors++; $display("FAIL load_rdata_at_valid got %h want dead", sr); end
        checks++; if (rdata_out !== exp_rdata) begin errors++; $display("FAIL load_rdata_hold got %h want %h", rdata_out, exp_rdata); end
    endtask

    task automatic test_store();
        int ns, nr, nv, nt; logic [63:0] sa, sw, sr; logic swe;
        do_access(1'b1, 1'b0, 64'h8, 64'h1234, 1, 64'hBAD0, ns, nr, nv, nt, sa, sw, sr, swe);
        checks++; if (sa !== 64'h8) begin errors++; $display("FAIL store_addr got %h want 8", sa); end
        checks++; if (swe !== 1'b1) begin errors++; $display("FAIL store_we got %b want 1", swe); end
        checks++; if (sw !== 64'h1234) begin errors++; $display("FAIL store_wdata got %h want 1234", sw); end
        checks++; if (ns !== 2) begin errors++; $display("FAIL store_stall_cycles got %0d want 2", ns); end
        checks++; if (nv !== 0) begin errors++; $display("FAIL store_valid_cycles got %0d want 0", nv); end
        checks++; if (rdata_out !== exp_rdata) begin errors++; $display("FAIL store_rdata_kept got %h want %h", rdata_out, exp_rdata); end
    endtask

    task automatic test_both();
        int ns, nr, nv, nt; logic [63:0] sa, sw, sr; logic swe;
        do_access(1'b1, 1'b1, 64'h100, 64'hCAFE, 2, 64'hF00D, ns, nr, nv, nt, sa, sw, sr, swe);
        checks++; if (swe !== 1'b1) begin errors++; $display("FAIL both_we got %b want 1", swe); end
        checks++; if (sw !== 64'hCAFE) begin errors++; $display("FAIL both_wdata got %h want cafe", sw); end
        checks++; if (nv !== 0) begin errors++; $display("FAIL both_valid_cycles got %0d want 0", nv); end
        checks++; if (rdata_out !== exp_rdata) begin errors++; $display("FAIL both_rdata_kept got %h want %h", rdata_out, exp_rdata); end
    endtask

    task automatic test_reset_in_req();
        int ns, nr, nv, nt; logic [63:0] sa, sw, sr; logic swe;
        @(negedge clk);
        MemWrite = 1'b0; MemToReg = 1'b1; Daddr = 64'h2A0; Db = '0; mem_ack = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            MemToReg = 1'b0;
            reset = k == 3 ? 1'b0 : 1'b1;
            #1;
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstreq_req_cycle%0d got %b want 1", k, mem_req); end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        exp_rdata = '0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstreq_req_after got %b want 0", mem_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstreq_stall_after got %b want 0", stall); end
        checks++; if (mem_addr !== 64'd0) begin errors++; $display("FAIL rstreq_addr_cleared got %h want 0", mem_addr); end
        @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstreq_stays_idle got %b want 0", mem_req); end
        do_access(1'b0, 1'b1, 64'h2A8, '0, 3, 64'h5A5A, ns, nr, nv, nt, sa, sw, sr, swe);
        exp_rdata = 64'h5A5A;
        checks++; if (nv !== 1 || sr !== 64'h5A5A) begin errors++; $display("FAIL rstreq_followup_load got valid=%0d data=%h want 1 5a5a", nv, sr); end
        checks++; if (sa !== 64'h2A8 || ns !== 4) begin errors++; $display("FAIL rstreq_followup_shape got addr=%h stall=%0d want 2a8 4", sa, ns); end
    endtask

    task automatic test_spurious_ack();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            MemWrite = 1'b0; MemToReg = 1'b0; mem_ack = 1'b1; mem_rdata = {$urandom, $urandom};
            #1;
            checks++;
            if (mem_req !== 1'b0 || stall !== 1'b0 || rdata_valid !== 1'b0 || rdata_out !== exp_rdata) begin
                errors++;
                $display("FAIL spurious_ack_%0d got req=%b stall=%b valid=%b rdata=%h want 0 0 0 %h", k, mem_req, stall, rdata_valid, rdata_out, exp_rdata);
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++; if (rdata_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL spurious_ack_after got valid=%b req=%b want 0 0", rdata_valid, mem_req); end
    endtask

    task automatic test_timeout();
        int ns, nr, nv, nt; logic [63:0] sa, sw, sr; logic swe;
        int lat = TMO ? 100 : 30;
        do_access(1'b0, 1'b1, 64'h300, '0, lat, 64'h9999, ns, nr, nv, nt, sa, sw, sr, swe);
        exp_rdata = TMO ? 64'd0 : 64'h9999;
        checks++; if (nr !== (TMO ? T : lat)) begin errors++; $display("FAIL long_wait_req_cycles got %0d want %0d", nr, TMO ? T : lat); end
        checks++; if (nt !== (TMO ? 1 : 0)) begin errors++; $display("FAIL long_wait_timeout_cycles got %0d want %0d", nt, TMO ? 1 : 0); end
        checks++; if (nv !== (TMO ? 0 : 1)) begin errors++; $display("FAIL long_wait_valid_cycles got %0d want %0d", nv, TMO ? 0 : 1); end
        checks++; if (rdata_out !== exp_rdata) begin errors++; $display("FAIL long_wait_rdata got %h want %h", rdata_out, exp_rdata); end
        do_access(1'b0, 1'b1, 64'h308, '0, T, 64'h4444, ns, nr, nv, nt, sa, sw, sr, swe);
        exp_rdata = 64'h4444;
        checks++; if (nt !== 0) begin errors++; $display("FAIL ack_at_limit_timeout got %0d want 0", nt); end
        checks++; if (nv !== 1 || rdata_out !== exp_rdata) begin errors++; $display("FAIL ack_at_limit_load got valid=%0d rdata=%h want 1 %h", nv, rdata_out, exp_rdata); end
    endtask

    // Back-to-back random accesses compared against a transaction-level expectation.
    task automatic test_random();
        int ns, nr, nv, nt; logic [63:0] sa, sw, sr; logic swe;
        for (int i = 0; i < 40; i++) begin
            int kind = $urandom_range(1, 3);
            logic w = kind[0];
            logic r = kind[1];
            int lat = $urandom_range(1, 6);
            logic [63:0] a = {$urandom, $urandom};
            logic [63:0] d = {$urandom, $urandom};
            logic [63:0] rd = {$urandom, $urandom};
            bit tmo = TMO && lat > T;
            int reqs = tmo ? T : lat;
            bit load_ok = !w && !tmo;
            do_access(w, r, a, d, lat, rd, ns, nr, nv, nt, sa, sw, sr, swe);
            if (tmo) exp_rdata = '0;
            else if (!w) exp_rdata = rd;
            checks++;
            if (sa !== a || sw !== d || swe !== w) begin
                errors++;
                $display("FAIL rand%0d_latch got addr=%h wdata=%h we=%b want %h %h %b", i, sa, sw, swe, a, d, w);
            end
            checks++;
            if (nr !== reqs || ns !== reqs + 1 || nt !== int'(tmo)) begin
                errors++;
                $display("FAIL rand%0d_timing got req=%0d stall=%0d tmo=%0d want %0d %0d %0d", i, nr, ns, nt, reqs, reqs + 1, int'(tmo));
            end
            checks++;
            if (nv !== int'(load_ok) || rdata_out !== exp_rdata || (load_ok && sr !== rd)) begin
                errors++;
                $display("FAIL rand%0d_result got valid=%0d rdata=%h want %0d %h", i, nv, rdata_out, int'(load_ok), exp_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_both();
        test_spurious_ack();
        test_reset_in_req();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
